long_prim_decoder: RTL and testbench
====================================

Name: long_prim_decoder

Overview:
- Iterative inverse of the serial XOR/NOT primitive chain used in simulator evaluation circuits.
- Takes a codeword produced by DEPTH forward stages over IO_PAIRS bit-pairs and recovers the original input, undoing one stage per clock.
- Sits between the chain output and the checker in a performance-evaluation netlist.
- Gives the simulator a stateful, handshaken workload that mirrors the combinational encoder.

Parameters:
- IO_PAIRS, 2, number of independent (a,b) bit-pairs; data width W = 2*IO_PAIRS.
- DEPTH, 32, number of forward stages to undo; legal range 1..1024; elaboration error otherwise.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  codeword present on in_code.
- in_ready  output  1  decoder accepts a codeword this cycle.
- in_code  input  W  codeword; pair j: a' = bit 2j, b' = bit 2j+1.
- out_valid  output  1  decoded word on out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  W  recovered input word.
- busy  output  1  high while stages are being undone (RUN).

Behaviour:
- Forward stage per pair, for reference: b_next = a ^ b; a_next = ~a.
- Inverse stage per pair: a = ~a'; b = b' ^ ~a'. All pairs are updated in parallel each RUN cycle.
- Reset (rst_n low, async assert) forces:
  - state IDLE, work register 0, count 0;
  - outputs in_ready=1, out_valid=0, out_data=0, busy=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load work<=in_code, count<=0, go to RUN.
  - RUN: in_ready=0, busy=1. Each edge applies one inverse stage to work and increments count. On the edge where count==DEPTH-1 (the DEPTH-th stage), go to DONE.
  - DONE: out_valid=1, out_data=work, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises exactly DEPTH edges after the accepting edge.
- Throughput: one word per DEPTH+2 cycles. No input acceptance in RUN or DONE.
- Input is ignored while in_ready=0. in_code need not be held after acceptance.
- out_data is registered. It keeps its last value after the DONE handshake until the next DONE.
  - Checker compares only when out_valid=1.
- Count width is clog2(DEPTH+1). The counter never wraps: it is cleared on accept and stops at DEPTH-1.
- DEPTH=1: RUN lasts exactly one cycle.
- Reset asserted mid-RUN or mid-DONE: the word is discarded and no out_valid pulse occurs. Return to IDLE immediately, asynchronously.
- out_ready may be high before DONE; it has no effect outside DONE.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes. Input is accepted on a later IDLE cycle.
- Functional identity (checker oracle): after the full decode, a = a' if DEPTH is even and ~a' if odd.
  - b = b' ^ (a-parity term). For DEPTH=32 the decode is the identity.

Decomposition:
- Shared package long_prim_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - a function inv_stage(word) implementing one inverse stage over IO_PAIRS;
  - a function fwd_stage(word), used by the bench scoreboard.
- One natural sub-module, long_prim_inv_stage: a combinational single inverse stage, instantiated once and fed from the work register.

Test Plan:
- IO_PAIRS=2, DEPTH=1, in_code=4'b0110 accepted -> out_valid after 1 edge, out_data=4'b0001.
- IO_PAIRS=2, DEPTH=3, in_code=4'b0110 -> out_valid after 3 edges, out_data=4'b1011; busy high exactly 3 cycles.
- IO_PAIRS=2, DEPTH=32, in_code=4'b1011 -> out_valid after 32 edges, out_data=4'b1011 (identity).
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable. in_ready=0 throughout; in_valid pulses meanwhile are dropped.
- Reset mid-RUN at count=5 (DEPTH=32) -> immediate in_ready=1, busy=0, out_valid=0. A new word 4'b1100 then decodes to 4'b1100 in 32 edges.
- Random 200 words, DEPTH=7, random out_ready -> every out_data, passed through fwd_stage seven times, equals the accepted in_code, in order.

Source files
------------

// File: rtl/long_prim_pkg.sv
// Shared state type and single-stage helpers for the XOR/NOT primitive chain.
// Helpers work on a fixed maximum width; callers zero-extend and slice.
package long_prim_pkg;

  localparam int MAX_PAIRS = 16;
  localparam int MAX_W     = 2 * MAX_PAIRS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Pair j: a in bit 2j, b in bit 2j+1. Undo b_next = a ^ b, a_next = ~a.
  function automatic logic [MAX_W-1:0] inv_stage(input logic [MAX_W-1:0] word);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int j = 0; j < MAX_PAIRS; j++) begin
      res[2*j]   = ~word[2*j];
      res[2*j+1] = word[2*j+1] ^ ~word[2*j];
    end
    return res;
  endfunction

  function automatic logic [MAX_W-1:0] fwd_stage(input logic [MAX_W-1:0] word);
    logic [MAX_W-1:0] res;
    res = '0;
    for (int j = 0; j < MAX_PAIRS; j++) begin
      res[2*j]   = ~word[2*j];
      res[2*j+1] = word[2*j] ^ word[2*j+1];
    end
    return res;
  endfunction

endpackage

// File: rtl/long_prim_inv_stage.sv
// Combinational single inverse stage over IO_PAIRS bit-pairs.
module long_prim_inv_stage
  import long_prim_pkg::*;
#(
  parameter int IO_PAIRS = 2
) (
  input  logic [2*IO_PAIRS-1:0] i_word,
  output logic [2*IO_PAIRS-1:0] o_word
);

  localparam int W = 2 * IO_PAIRS;

  logic [MAX_W-1:0] w_ext;
  logic [MAX_W-1:0] w_res;

  assign w_ext  = MAX_W'(i_word);
  assign w_res  = inv_stage(w_ext);
  assign o_word = w_res[W-1:0];

  // Pairs above IO_PAIRS only ever see zeros and are dropped.
  generate
    if (W < MAX_W) begin : g_highPairs
      logic w_unusedHigh;
      assign w_unusedHigh = ^w_res[MAX_W-1:W];
    end
  endgenerate

endmodule

// File: rtl/long_prim_decoder.sv
// Iterative decoder: loads a chain codeword, undoes one stage per clock for
// DEPTH clocks, then presents the recovered word until the consumer takes it.
module long_prim_decoder
  import long_prim_pkg::*;
#(
  parameter int IO_PAIRS = 2,
  parameter int DEPTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IO_PAIRS-1:0] in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IO_PAIRS-1:0] out_data,
  output logic                  busy
);

  localparam int W  = 2 * IO_PAIRS;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEPTH - 1);

  generate
    if (DEPTH < 1 || DEPTH > 1024) begin : g_badDepth
      $error("long_prim_decoder: DEPTH must be in 1..1024");
    end
    if (IO_PAIRS < 1 || IO_PAIRS > MAX_PAIRS) begin : g_badPairs
      $error("long_prim_decoder: IO_PAIRS out of supported range");
    end
  endgenerate

  state_t         r_state;
  state_t         w_stateNext;
  logic [W-1:0]   r_work;
  logic [W-1:0]   r_outData;
  logic [W-1:0]   w_stageOut;
  logic [CW-1:0]  r_count;
  logic           w_lastStage;

  long_prim_inv_stage #(
    .IO_PAIRS(IO_PAIRS)
  ) u_invStage (
    .i_word(r_work),
    .o_word(w_stageOut)
  );

  assign w_lastStage = (r_count == LAST_COUNT);
  assign out_data    = r_outData;

  always_comb begin
    w_stateNext = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastStage) w_stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The result is captured on the final RUN edge so it appears together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_count   <= '0;
      r_outData <= '0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work  <= in_code;
            r_count <= '0;
          end
        end
        RUN: begin
          r_work <= w_stageOut;
          if (w_lastStage) r_outData <= w_stageOut;
          else             r_count   <= r_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_long_prim_decoder.sv
// Bench for long_prim_decoder: four instances (DEPTH 1, 3, 32, 7) checked
// against a closed-form decode model and a forward-chain round trip.
module tb_long_prim_decoder;
  import long_prim_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid  [4];
  logic [3:0] inCode   [4];
  logic       outReady [4];
  logic       inReady  [4];
  logic       outValid [4];
  logic       busy     [4];
  logic [3:0] outData  [4];
  int         depthTab [4] = '{1, 3, 32, 7};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  long_prim_decoder #(.IO_PAIRS(2), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_code(inCode[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .busy(busy[0]));

  long_prim_decoder #(.IO_PAIRS(2), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_code(inCode[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .busy(busy[1]));

  long_prim_decoder #(.IO_PAIRS(2), .DEPTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_code(inCode[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_data(outData[2]), .busy(busy[2]));

  long_prim_decoder #(.IO_PAIRS(2), .DEPTH(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
    .in_code(inCode[3]), .out_valid(outValid[3]), .out_ready(outReady[3]),
    .out_data(outData[3]), .busy(busy[3]));

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Closed form of DEPTH inverse stages: a flips on odd depth, b cycles with period 4.
  function automatic logic [3:0] expectDecode(input logic [3:0] code, input int depth);
    logic [3:0] res;
    logic a, b;
    res = '0;
    for (int p = 0; p < 2; p++) begin
      a = code[2*p];
      b = code[2*p+1];
      res[2*p] = (depth % 2 == 1) ? ~a : a;
      case (depth % 4)
        0:       res[2*p+1] = b;
        1:       res[2*p+1] = b ^ ~a;
        2:       res[2*p+1] = ~b;
        default: res[2*p+1] = b ^ a;
      endcase
    end
    return res;
  endfunction

  task automatic applyStimulus(input int k, input logic [3:0] code);
    checkOutput($sformatf("ready_before_accept_%0d", k), 32'(inReady[k]), 32'd1);
    inValid[k] = 1'b1;
    inCode[k]  = code;
    @(negedge clk);
    inValid[k] = 1'b0;
    inCode[k]  = 4'($urandom);
  endtask

  task automatic waitDone(input int k, output int edges, output int busyCycles);
    edges      = 0;
    busyCycles = 0;
    while (!outValid[k] && edges < depthTab[k] + 10) begin
      if (busy[k]) busyCycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic runDirected(input int k, input logic [3:0] code, input logic [3:0] expected);
    int edges, busyCycles;
    applyStimulus(k, code);
    waitDone(k, edges, busyCycles);
    checkOutput($sformatf("latency_d%0d", depthTab[k]), 32'(edges), 32'(depthTab[k]));
    checkOutput($sformatf("busy_cycles_d%0d", depthTab[k]), 32'(busyCycles), 32'(depthTab[k]));
    checkOutput($sformatf("data_d%0d", depthTab[k]), 32'(outData[k]), 32'(expected));
    checkOutput($sformatf("model_d%0d", depthTab[k]), 32'(outData[k]),
                32'(expectDecode(code, depthTab[k])));
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [3:0]       q[$];
    logic [3:0]       expCode;
    logic [MAX_W-1:0] t;
    int sent, got, cyc;

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inValid[k]  = 1'b0;
      inCode[k]   = '0;
      outReady[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("reset_in_ready_%0d", k), 32'(inReady[k]), 32'd1);
      checkOutput($sformatf("reset_out_valid_%0d", k), 32'(outValid[k]), 32'd0);
      checkOutput($sformatf("reset_out_data_%0d", k), 32'(outData[k]), 32'd0);
      checkOutput($sformatf("reset_busy_%0d", k), 32'(busy[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // DEPTH=1 then release
    runDirected(0, 4'b0110, 4'b0001);
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
    checkOutput("d1_released", 32'(outValid[0]), 32'd0);

    // DEPTH=3 with backpressure and dropped input pulses
    runDirected(1, 4'b0110, 4'b1011);
    for (int i = 0; i < 10; i++) begin
      inValid[1] = i[0];
      inCode[1]  = 4'($urandom);
      @(negedge clk);
      checkOutput("bp_valid", 32'(outValid[1]), 32'd1);
      checkOutput("bp_data", 32'(outData[1]), 32'b1011);
      checkOutput("bp_in_ready", 32'(inReady[1]), 32'd0);
    end
    inValid[1]  = 1'b1;
    inCode[1]   = 4'b0101;
    outReady[1] = 1'b1;
    @(negedge clk);
    inValid[1]  = 1'b0;
    outReady[1] = 1'b0;
    checkOutput("simul_out_valid", 32'(outValid[1]), 32'd0);
    checkOutput("simul_not_accepted", 32'(busy[1]), 32'd0);
    checkOutput("simul_in_ready", 32'(inReady[1]), 32'd1);
    checkOutput("data_held_after_done", 32'(outData[1]), 32'b1011);
    @(negedge clk);
    checkOutput("simul_still_idle", 32'(busy[1]), 32'd0);

    // DEPTH=32 identity
    runDirected(2, 4'b1011, 4'b1011);
    outReady[2] = 1'b1;
    @(negedge clk);
    outReady[2] = 1'b0;

    // Async reset mid-RUN at count 5
    applyStimulus(2, 4'($urandom));
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_in_ready", 32'(inReady[2]), 32'd1);
    checkOutput("mid_reset_busy", 32'(busy[2]), 32'd0);
    checkOutput("mid_reset_out_valid", 32'(outValid[2]), 32'd0);
    checkOutput("mid_reset_out_data", 32'(outData[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_no_valid", 32'(outValid[2]), 32'd0);
    runDirected(2, 4'b1100, 4'b1100);
    outReady[2] = 1'b1;
    @(negedge clk);
    outReady[2] = 1'b0;

    // Random traffic on DEPTH=7 with random consumer stalls
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 200 && cyc < 20000) begin
      inValid[3]  = (sent < 200) && ($urandom_range(0, 3) != 0);
      inCode[3]   = 4'($urandom);
      outReady[3] = 1'($urandom_range(0, 1));
      if (inValid[3] && inReady[3]) begin
        q.push_back(inCode[3]);
        sent++;
      end
      if (outValid[3] && outReady[3]) begin
        if (q.size() == 0) begin
          checkOutput("rand_spurious_output", 32'd1, 32'd0);
        end else begin
          expCode = q.pop_front();
          checkOutput("rand_decode", 32'(outData[3]), 32'(expectDecode(expCode, 7)));
          t = MAX_W'(outData[3]);
          for (int i = 0; i < 7; i++) t = fwd_stage(t);
          checkOutput("rand_roundtrip", 32'(t[3:0]), 32'(expCode));
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    inValid[3]  = 1'b0;
    outReady[3] = 1'b0;
    checkOutput("rand_word_count", 32'(got), 32'd200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
